// File: rtl/pll_lock_reset_sequencer.sv
// pll_lock_reset_sequencer
//
// Watches the ECP5 EHXPLLL LOCK output and drives the PLL RST pin. It also
// produces the registered system reset for the CPU, decode, palette and cache
// logic. The system is released only after the synchronised lock has stayed
// high for a stability window plus a hold period. Loss of lock, relock
// timeout or a software request re-runs the sequence. Everything runs on the
// 25 MHz reference clock, so the sequencer keeps working while the PLL is
// unlocked.
//
// Ports:
//   clkin           in   25 MHz reference clock (the only clock)
//   rst_n           in   asynchronous active-low reset
//   pll_locked      in   asynchronous LOCK from the PLL
//   soft_pll_rst    in   single-cycle request to re-run the full sequence
//   pll_rst         out  active-high reset to the PLL RST pin
//   sys_reset       out  active-high system reset
//   sys_ready       out  high only in RUN
//   lock_loss_count out  saturating count of lock drops seen in RUN
//   seq_state       out  current state encoding (debug)
module pll_lock_reset_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLLRST_CYCLES  = 16,
   parameter int STABLE_CYCLES  = 25000,
   parameter int HOLD_CYCLES    = 64,
   parameter int RELOCK_TIMEOUT = 250000
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_pll_rst,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       sys_ready,
   output logic [7:0] lock_loss_count,
   output logic [2:0] seq_state
);

   localparam int MAX_AB  = (PLLRST_CYCLES > STABLE_CYCLES) ? PLLRST_CYCLES : STABLE_CYCLES;
   localparam int MAX_CD  = (HOLD_CYCLES > RELOCK_TIMEOUT) ? HOLD_CYCLES : RELOCK_TIMEOUT;
   localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int TIMER_W = $clog2(MAX_ALL) + 1;

   localparam logic [TIMER_W-1:0] PLLRST_LAST = TIMER_W'(PLLRST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RELOCK_LAST = TIMER_W'(RELOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      PLLRST    = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } seqState_t;

   seqState_t                  state;
   seqState_t                  stateNext;
   logic [TIMER_W-1:0]         timer;
   logic [TIMER_W-1:0]         timerNext;
   logic [SYNC_STAGES-1:0]     syncFf;
   logic                       lkS;
   logic                       countInc;

   function automatic logic [7:0] satInc8(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

   // Lock synchroniser: shift pll_locked in at bit 0, use the top bit.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         syncFf <= '0;
      end else begin
         syncFf <= {syncFf[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign lkS = syncFf[SYNC_STAGES-1];

   // Next-state logic. A software request overrides everything, including a
   // simultaneous lock drop in RUN, which then is not counted.
   always_comb begin
      stateNext = state;
      countInc  = 1'b0;
      if (soft_pll_rst) begin
         stateNext = PLLRST;
      end else begin
         case (state)
            PLLRST: begin
               if (timer == PLLRST_LAST) stateNext = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lkS)                       stateNext = STABLE;
               else if (timer == RELOCK_LAST) stateNext = PLLRST;
            end
            STABLE: begin
               if (!lkS)                      stateNext = WAIT_LOCK;
               else if (timer == STABLE_LAST) stateNext = RELEASE;
            end
            RELEASE: begin
               if (!lkS)                    stateNext = WAIT_LOCK;
               else if (timer == HOLD_LAST) stateNext = RUN;
            end
            RUN: begin
               if (!lkS) begin
                  stateNext = WAIT_LOCK;
                  countInc  = 1'b1;
               end
            end
            default: stateNext = PLLRST;
         endcase
      end
   end

   // Shared timer restarts on every state entry (a soft request re-entering
   // PLLRST counts as an entry). It holds at all-ones instead of wrapping
   // during long stays in RUN.
   always_comb begin
      timerNext = timer;
      if (soft_pll_rst || (stateNext != state)) begin
         timerNext = '0;
      end else if (timer != '1) begin
         timerNext = timer + 1'b1;
      end
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as the state register.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state           <= PLLRST;
         timer           <= '0;
         pll_rst         <= 1'b1;
         sys_reset       <= 1'b1;
         sys_ready       <= 1'b0;
         lock_loss_count <= 8'd0;
      end else begin
         state     <= stateNext;
         timer     <= timerNext;
         pll_rst   <= (stateNext == PLLRST);
         sys_reset <= (stateNext != RUN);
         sys_ready <= (stateNext == RUN);
         if (countInc) lock_loss_count <= satInc8(lock_loss_count);
      end
   end

   assign seq_state = state;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
module tb_pll_lock_reset_sequencer;

   logic       clkin;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_pll_rst;
   logic       pll_rst;
   logic       sys_reset;
   logic       sys_ready;
   logic [7:0] lock_loss_count;
   logic [2:0] seq_state;

   pll_lock_reset_sequencer #(
      .SYNC_STAGES   (2),
      .PLLRST_CYCLES (4),
      .STABLE_CYCLES (8),
      .HOLD_CYCLES   (4),
      .RELOCK_TIMEOUT(32)
   ) dut (
      .clkin          (clkin),
      .rst_n          (rst_n),
      .pll_locked     (pll_locked),
      .soft_pll_rst   (soft_pll_rst),
      .pll_rst        (pll_rst),
      .sys_reset      (sys_reset),
      .sys_ready      (sys_ready),
      .lock_loss_count(lock_loss_count),
      .seq_state      (seq_state)
   );

   typedef struct {
      int         cyc;
      string      tag;
      logic [2:0] st;
      logic       pr;
      logic       sr;
      logic       rdy;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sbQ[$];
   int         cyc = 0;
   int         nAsserts = 0;
   int         nFails = 0;
   logic [7:0] expCnt = 8'd0;

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   always @(posedge clkin) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int ahead, input string tag, input logic [2:0] st,
                       input logic pr, input logic sr, input logic rdy, input logic [7:0] cnt);
      exp_t e;
      e.cyc = cyc + ahead;
      e.tag = tag;
      e.st  = st;
      e.pr  = pr;
      e.sr  = sr;
      e.rdy = rdy;
      e.cnt = cnt;
      sbQ.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clkin);
   endtask

   // Scoreboard: compare every entry whose target edge has just occurred.
   always @(negedge clkin) begin
      for (int i = sbQ.size() - 1; i >= 0; i--) begin
         if (sbQ[i].cyc == cyc) begin
            chk($sformatf("%s@%0d.state", sbQ[i].tag, cyc), {5'd0, seq_state}, {5'd0, sbQ[i].st});
            chk($sformatf("%s@%0d.pll_rst", sbQ[i].tag, cyc), {7'd0, pll_rst}, {7'd0, sbQ[i].pr});
            chk($sformatf("%s@%0d.sys_reset", sbQ[i].tag, cyc), {7'd0, sys_reset}, {7'd0, sbQ[i].sr});
            chk($sformatf("%s@%0d.sys_ready", sbQ[i].tag, cyc), {7'd0, sys_ready}, {7'd0, sbQ[i].rdy});
            chk($sformatf("%s@%0d.count", sbQ[i].tag, cyc), lock_loss_count, sbQ[i].cnt);
            sbQ.delete(i);
         end
      end
   end

   // From WAIT_LOCK (entered on the edge just before this negedge): raise the
   // lock and follow it through STABLE and RELEASE into RUN.
   task automatic raiseToRun(input string tag);
      pll_locked = 1'b1;
      push(2,  {tag, "_wait"},   3'd1, 1'b0, 1'b1, 1'b0, expCnt);
      push(3,  {tag, "_stable"}, 3'd2, 1'b0, 1'b1, 1'b0, expCnt);
      push(10, {tag, "_stbEnd"}, 3'd2, 1'b0, 1'b1, 1'b0, expCnt);
      push(11, {tag, "_rel"},    3'd3, 1'b0, 1'b1, 1'b0, expCnt);
      push(14, {tag, "_relEnd"}, 3'd3, 1'b0, 1'b1, 1'b0, expCnt);
      push(15, {tag, "_run"},    3'd4, 1'b0, 1'b0, 1'b1, expCnt);
      step(15);
   endtask

   // From RUN: drop the lock, expect WAIT_LOCK two edges after it is first
   // sampled with the count bumped, then relock.
   task automatic dropAndRelock(input string tag);
      logic [7:0] nextCnt;
      pll_locked = 1'b0;
      nextCnt = (expCnt == 8'hFF) ? 8'hFF : expCnt + 8'd1;
      push(2, {tag, "_still_run"}, 3'd4, 1'b0, 1'b0, 1'b1, expCnt);
      push(3, {tag, "_dropped"},   3'd1, 1'b0, 1'b1, 1'b0, nextCnt);
      expCnt = nextCnt;
      step(3);
      raiseToRun({tag, "_relock"});
   endtask

   initial begin
      int c0;
      rst_n        = 1'b1;
      pll_locked   = 1'b0;
      soft_pll_rst = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset.state", {5'd0, seq_state}, 8'd0);
      chk("reset.pll_rst", {7'd0, pll_rst}, 8'd1);
      chk("reset.sys_reset", {7'd0, sys_reset}, 8'd1);
      chk("reset.sys_ready", {7'd0, sys_ready}, 8'd0);
      chk("reset.count", lock_loss_count, 8'd0);
      step(2);
      rst_n = 1'b1;

      // Lock held low: PLLRST 4 cycles, WAIT_LOCK 32 cycles, repeat.
      push(1,  "noLock_pllrst",    3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      push(3,  "noLock_pllrstEnd", 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      push(4,  "noLock_wait",      3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      push(35, "noLock_waitEnd",   3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      push(36, "noLock_timeout",   3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      push(39, "noLock_pllrst2",   3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      push(40, "noLock_wait2",     3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      step(40);

      // One-cycle lock glitch in STABLE restarts the stability window.
      pll_locked = 1'b1;
      push(2,  "glitch_wait",     3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      push(3,  "glitch_stable",   3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      push(8,  "glitch_stable2",  3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      push(9,  "glitch_back",     3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      push(10, "glitch_restable", 3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      push(17, "glitch_stbEnd",   3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      push(18, "glitch_rel",      3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
      push(21, "glitch_relEnd",   3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
      push(22, "glitch_run",      3'd4, 1'b0, 1'b0, 1'b1, 8'd0);
      step(6);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(15);

      // Three lock drops in RUN.
      for (int k = 1; k <= 3; k++) dropAndRelock($sformatf("drop%0d", k));
      chk("count_after_3", lock_loss_count, 8'd3);

      // Soft request on the same edge the synchronised lock drop is seen.
      pll_locked = 1'b0;
      push(1, "soft_pre1", 3'd4, 1'b0, 1'b0, 1'b1, expCnt);
      push(2, "soft_pre2", 3'd4, 1'b0, 1'b0, 1'b1, expCnt);
      step(2);
      soft_pll_rst = 1'b1;
      push(1, "soft_pllrst",    3'd0, 1'b1, 1'b1, 1'b0, expCnt);
      push(4, "soft_pllrstEnd", 3'd0, 1'b1, 1'b1, 1'b0, expCnt);
      push(5, "soft_wait",      3'd1, 1'b0, 1'b1, 1'b0, expCnt);
      step(1);
      soft_pll_rst = 1'b0;
      step(4);

      // Clean lock from WAIT_LOCK: release exactly 14 edges after first sample.
      raiseToRun("latency");

      // Remaining drops up to 300 total; count saturates at 255.
      for (int k = 4; k <= 300; k++) dropAndRelock($sformatf("drop%0d", k));
      chk("count_saturated", lock_loss_count, 8'd255);

      // Asynchronous reset between clock edges while in RUN.
      #2 rst_n = 1'b0;
      #1;
      chk("arst.state", {5'd0, seq_state}, 8'd0);
      chk("arst.pll_rst", {7'd0, pll_rst}, 8'd1);
      chk("arst.sys_reset", {7'd0, sys_reset}, 8'd1);
      chk("arst.sys_ready", {7'd0, sys_ready}, 8'd0);
      chk("arst.count", lock_loss_count, 8'd0);
      step(2);
      rst_n = 1'b1;
      c0 = cyc;
      // Lock already high while in PLLRST: one cycle in WAIT_LOCK.
      push(1,  "rearm_pllrst",    3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      push(3,  "rearm_pllrstEnd", 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      push(4,  "rearm_wait",      3'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      push(5,  "rearm_stable",    3'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      push(16, "rearm_rel",       3'd3, 1'b0, 1'b1, 1'b0, 8'd0);
      push(17, "rearm_run",       3'd4, 1'b0, 1'b0, 1'b1, 8'd0);
      step(19);
      chk("sb_drained", 8'(sbQ.size()), 8'd0);
      chk("rearm_elapsed", 8'(cyc - c0), 8'd19);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d required < 200000", cyc);
      $fatal(1, "watchdog");
   end

endmodule
